mpu_ctlif_mc: RTL and testbench
===============================

Name: mpu_ctlif_mc

Overview:
- Multi-channel successor of the single-MPU control interface.
- Controls NCHAN MPU instances from one CSR bank: per-channel run and reset.
- Captures per-channel error and user-IRQ events, with UDATA_W bits of user data, into a shared event FIFO. Software drains the FIFO via CSR.
- Drives one level interrupt to the system IRQ controller.

Parameters:
- CSR_ADDR, 4'h0: bank select, compared against csr_a[13:10].
- NCHAN, 4: number of MPU channels, 1..16.
- UDATA_W, 64: user data width per channel; multiple of 32, max 256.
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-low.
- csr_a  in  14  CSR word address.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data; registered.
- mpu_en  out  NCHAN  per-channel run enable.
- mpu_rst  out  NCHAN  per-channel one-cycle reset pulse.
- user_irq  in  NCHAN  per-channel user interrupt, synchronous to sys_clk.
- user_data  in  NCHAN*UDATA_W  channel i occupies bits [i*UDATA_W +: UDATA_W].
- error  in  NCHAN  per-channel error, synchronous to sys_clk.
- irq  out  1  level interrupt to the CPU.

Behaviour:
- Reset values (sys_rst low): csr_do=0, mpu_en=0, mpu_rst=0, irq=0. FIFO empty, pending flags clear, ovf=0, irq_en=0.
- CSR selection: bank is selected when csr_a[13:10]==CSR_ADDR.
  - Reads: csr_do is valid one cycle after the address; it is 0 when the bank is not selected or the word is unmapped.
  - Writes: occur in the csr_we cycle.
- CSR word map (csr_a[9:0]):
  - 0x000 CTRL: rw; bit0 = irq_en.
  - 0x001 RUN: rw; bits[NCHAN-1:0] = mpu_en.
  - 0x002 RST: write-only, reads 0. Each 1 bit: mpu_rst[i]=1 for exactly the next cycle, and mpu_en[i] clears.
  - 0x003 STAT: read {ovf at bit31, level at bits[22:16], full at bit1, empty at bit0}. Writing bit31=1 clears ovf.
  - 0x004 EVT: read head entry {valid at bit31, type at bit8 (1=error, 0=user), chan at bits[3:0]}. Reads 0 when the FIFO is empty.
  - 0x005+k: head user_data word k, for k < UDATA_W/32, little-word order. Reads 0 for error entries.
  - 0x010 POP: any write pops the head. Pop on an empty FIFO is ignored.
- Event detection, per channel:
  - Rising edge of error[i] or user_irq[i], detected against a registered previous value.
  - On detection: set pending[i]; store type and, for user events, the user_data slice sampled in the edge cycle.
  - error and user_irq rising in the same cycle on one channel: error wins and user data is dropped.
- Auto-stop on events:
  - An error event clears mpu_en[i] in the edge cycle.
  - A user event whose sampled data is all zero ("end") also clears mpu_en[i].
  - Auto-stop overrides a simultaneous RUN write setting that bit.
- Arbitration into the FIFO:
  - At most one pending entry is pushed per cycle, lowest channel index first.
  - A push succeeds only if the FIFO is not full, or a pop happens in the same cycle. Otherwise the entry stays pending.
  - A new edge on a channel whose pending flag is still set is dropped and sets ovf (sticky).
  - If STAT write-clear and a new overflow occur in the same cycle, ovf stays 1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a level counter in 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves the level unchanged.
- irq: registered, equal to irq_en & ~empty. It rises one cycle after the first entry lands.
- A reset mid-operation drops all pending and FIFO contents immediately.

Test Plan:
- Reset, then read STAT -> 0x00000001; read RUN -> 0. mpu_en=0, irq=0 throughout.
- Write CTRL=1, RUN=0xF, then pulse error[2] -> mpu_en=0xB. EVT reads 0x80000102. irq=1 two cycles after the edge. Write POP -> STAT=0x00000001, irq=0.
- user_irq[1] edge with data 0xFFFF_FFFF_FFFF_FFFF -> EVT=0x80000001, words 0x005/0x006 read 0xFFFFFFFF, mpu_en[1] stays 1. Repeat with data 0 -> mpu_en[1] clears.
- error[0] and error[3] rise in the same cycle -> FIFO order: chan 0, then chan 3. Level=2 is readable in STAT bits[22:16].
- Generate 10 error edges across channels with no pops (FIFO_DEPTH=8) -> full=1, level=8. Extra edges on already-pending channels set ovf. Writing STAT bit31 clears ovf. Pops then drain the pending entries in order.
- Write RST=0x4 while RUN=0xF -> mpu_rst=0x4 for exactly one cycle; RUN reads 0xB.

Source files
------------

// File: rtl/mpu_ctlif_mc.sv
// Multi-channel MPU control interface: per-channel run/reset control, event
// capture into a shared FIFO drained over CSR, and a level IRQ.
module mpu_ctlif_mc #(
  parameter logic [3:0]  CSR_ADDR   = 4'h0,
  parameter int unsigned NCHAN      = 4,
  parameter int unsigned UDATA_W    = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [13:0]                csr_a,
  input  logic                       csr_we,
  input  logic [31:0]                csr_di,
  output logic [31:0]                csr_do,
  output logic [NCHAN-1:0]           mpu_en,
  output logic [NCHAN-1:0]           mpu_rst,
  input  logic [NCHAN-1:0]           user_irq,
  input  logic [NCHAN*UDATA_W-1:0]   user_data,
  input  logic [NCHAN-1:0]           error,
  output logic                       irq
);

  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = PW + 1;
  localparam int unsigned CIW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned NWORDS = UDATA_W / 32;

  logic                 irq_en;
  logic                 ovf;
  logic [NCHAN-1:0]     prev_err;
  logic [NCHAN-1:0]     prev_usr;
  logic [NCHAN-1:0]     pending;
  logic [NCHAN-1:0]     pend_type;
  logic [UDATA_W-1:0]   pend_data [NCHAN];
  logic                 fifo_type [FIFO_DEPTH];
  logic [3:0]           fifo_chan [FIFO_DEPTH];
  logic [UDATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        level;

  logic                 sel, wr_ctrl, wr_run, wr_rst, wr_stat, wr_pop;
  logic                 empty, full;
  logic [NCHAN-1:0]     err_edge, usr_edge, accept, stop;
  logic                 ovf_set;
  logic                 grant_vld;
  logic [CIW-1:0]       grant_idx;
  logic                 pop, push;
  logic [NCHAN-1:0]     pending_nxt;
  logic [NCHAN-1:0]     mpu_en_nxt;
  logic [31:0]          rd_val;
  logic                 unused_di;

  assign unused_di = &{1'b0, csr_di};

  assign sel     = (csr_a[13:10] == CSR_ADDR);
  assign wr_ctrl = sel & csr_we & (csr_a[9:0] == 10'h000);
  assign wr_run  = sel & csr_we & (csr_a[9:0] == 10'h001);
  assign wr_rst  = sel & csr_we & (csr_a[9:0] == 10'h002);
  assign wr_stat = sel & csr_we & (csr_a[9:0] == 10'h003);
  assign wr_pop  = sel & csr_we & (csr_a[9:0] == 10'h010);
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));

  // Edge detection; a second edge while the channel is still pending is lost
  always_comb begin
    err_edge = error & ~prev_err;
    usr_edge = user_irq & ~prev_usr;
    stop     = '0;
    for (int i = 0; i < NCHAN; i++) begin
      stop[i] = err_edge[i] | (usr_edge[i] & ~(|user_data[i*UDATA_W +: UDATA_W]));
    end
    accept  = (err_edge | usr_edge) & ~pending;
    ovf_set = |((err_edge | usr_edge) & pending);
  end

  // Lowest pending channel wins; descending scan leaves the lowest index last
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_vld = 1'b1;
        grant_idx = CIW'(i);
      end
    end
    pop         = wr_pop & ~empty;
    push        = grant_vld & (~full | pop);
    pending_nxt = pending;
    if (push) pending_nxt[grant_idx] = 1'b0;
    pending_nxt = pending_nxt | accept;
    mpu_en_nxt  = wr_run ? csr_di[NCHAN-1:0] : mpu_en;
    if (wr_rst) mpu_en_nxt = mpu_en_nxt & ~csr_di[NCHAN-1:0];
    mpu_en_nxt  = mpu_en_nxt & ~stop;
  end

  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (csr_a[9:0])
        10'h000: rd_val[0] = irq_en;
        10'h001: rd_val[NCHAN-1:0] = mpu_en;
        10'h003: begin
          rd_val[31]        = ovf;
          rd_val[16 +: LW]  = level;
          rd_val[1]         = full;
          rd_val[0]         = empty;
        end
        10'h004: begin
          if (!empty) begin
            rd_val[31]  = 1'b1;
            rd_val[8]   = fifo_type[rd_ptr];
            rd_val[3:0] = fifo_chan[rd_ptr];
          end
        end
        default: begin
          for (int k = 0; k < NWORDS; k++) begin
            if (csr_a[9:0] == 10'(5 + k) && !empty && !fifo_type[rd_ptr]) begin
              rd_val = fifo_data[rd_ptr][k*32 +: 32];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      csr_do    <= '0;
      mpu_en    <= '0;
      mpu_rst   <= '0;
      irq       <= 1'b0;
      irq_en    <= 1'b0;
      ovf       <= 1'b0;
      prev_err  <= '0;
      prev_usr  <= '0;
      pending   <= '0;
      pend_type <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      csr_do   <= rd_val;
      mpu_en   <= mpu_en_nxt;
      mpu_rst  <= wr_rst ? csr_di[NCHAN-1:0] : '0;
      irq      <= irq_en & ~empty;
      if (wr_ctrl) irq_en <= csr_di[0];
      ovf      <= (ovf & ~(wr_stat & csr_di[31])) | ovf_set;
      prev_err <= error;
      prev_usr <= user_irq;
      pending  <= pending_nxt;
      for (int i = 0; i < NCHAN; i++) begin
        if (accept[i]) pend_type[i] <= err_edge[i];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Payload storage; only reachable through valid flags, so no reset needed
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (accept[i]) pend_data[i] <= err_edge[i] ? '0 : user_data[i*UDATA_W +: UDATA_W];
    end
    if (push) begin
      fifo_type[wr_ptr] <= pend_type[grant_idx];
      fifo_chan[wr_ptr] <= 4'(grant_idx);
      fifo_data[wr_ptr] <= pend_data[grant_idx];
    end
  end

endmodule

// File: tb/tb_mpu_ctlif_mc.sv
// Testbench for mpu_ctlif_mc: directed scenarios then randomized traffic,
// checked every cycle against an event-queue reference model.
module tb_mpu_ctlif_mc;

  localparam int unsigned NCHAN   = 4;
  localparam int unsigned UDATA_W = 64;
  localparam int unsigned DEPTH   = 8;

  logic                     sys_clk;
  logic                     sys_rst;
  logic [13:0]              csr_a;
  logic                     csr_we;
  logic [31:0]              csr_di;
  logic [31:0]              csr_do;
  logic [NCHAN-1:0]         mpu_en;
  logic [NCHAN-1:0]         mpu_rst;
  logic [NCHAN-1:0]         user_irq;
  logic [NCHAN*UDATA_W-1:0] user_data;
  logic [NCHAN-1:0]         error;
  logic                     irq;

  int n_tests = 0;
  int n_fail  = 0;

  mpu_ctlif_mc #(
    .CSR_ADDR(4'h0), .NCHAN(NCHAN), .UDATA_W(UDATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
    .csr_di(csr_di), .csr_do(csr_do), .mpu_en(mpu_en), .mpu_rst(mpu_rst),
    .user_irq(user_irq), .user_data(user_data), .error(error), .irq(irq)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Reference model: events as a queue of records, pending slots per channel
  typedef struct {
    logic               is_err;
    logic [3:0]         chan;
    logic [UDATA_W-1:0] data;
  } ev_t;

  ev_t                q[$];
  logic [NCHAN-1:0]   m_en, m_rst, m_pend, m_ptype, m_prev_err, m_prev_usr;
  logic [UDATA_W-1:0] m_pdata [NCHAN];
  logic               m_irq, m_irq_en, m_ovf;
  logic [31:0]        m_do;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = '0; m_rst = '0; m_pend = '0; m_ptype = '0;
    m_prev_err = '0; m_prev_usr = '0;
    m_irq = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0; m_do = '0;
  endtask

  task automatic model_step();
    logic             sel;
    int               w;
    int               g;
    logic [31:0]      rd;
    bit               pop, push, irq_nx, ee, uu;
    logic [NCHAN-1:0] pend_old;
    ev_t              e;
    sel = (csr_a[13:10] == 4'h0);
    w   = int'(csr_a[9:0]);
    rd  = '0;
    if (sel) begin
      if (w == 0) rd = {31'b0, m_irq_en};
      else if (w == 1) rd = 32'(m_en);
      else if (w == 3) rd = {m_ovf, 8'b0, 7'(q.size()), 14'b0, q.size() == DEPTH, q.size() == 0};
      else if (w == 4 && q.size() > 0)
        rd = 32'h8000_0000 | (q[0].is_err ? 32'h100 : 32'h0) | 32'(q[0].chan);
      else if (w >= 5 && w < 5 + UDATA_W / 32 && q.size() > 0 && !q[0].is_err)
        rd = q[0].data[(w - 5) * 32 +: 32];
    end
    pop = sel && csr_we && w == 16 && q.size() > 0;
    g = -1;
    for (int i = 0; i < NCHAN; i++) if (m_pend[i] && g < 0) g = i;
    push   = (g >= 0) && (q.size() < DEPTH || pop);
    irq_nx = m_irq_en && q.size() > 0;
    pend_old = m_pend;
    if (sel && csr_we) begin
      if (w == 0) m_irq_en = csr_di[0];
      if (w == 1) m_en = csr_di[NCHAN-1:0];
      if (w == 3 && csr_di[31]) m_ovf = 1'b0;
    end
    m_rst = (sel && csr_we && w == 2) ? csr_di[NCHAN-1:0] : '0;
    m_en  = m_en & ~m_rst;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.is_err = m_ptype[g];
      e.chan   = 4'(g);
      e.data   = m_pdata[g];
      q.push_back(e);
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < NCHAN; i++) begin
      ee = error[i] && !m_prev_err[i];
      uu = user_irq[i] && !m_prev_usr[i];
      if (ee || (uu && user_data[i*UDATA_W +: UDATA_W] == '0)) m_en[i] = 1'b0;
      if (ee || uu) begin
        if (pend_old[i]) m_ovf = 1'b1;
        else begin
          m_pend[i]  = 1'b1;
          m_ptype[i] = ee;
          m_pdata[i] = ee ? '0 : user_data[i*UDATA_W +: UDATA_W];
        end
      end
    end
    m_prev_err = error;
    m_prev_usr = user_irq;
    m_do  = rd;
    m_irq = irq_nx;
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_step();
    #1;
    check("csr_do", csr_do, m_do);
    check("mpu_en", 32'(mpu_en), 32'(m_en));
    check("mpu_rst", 32'(mpu_rst), 32'(m_rst));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic csr_rd(input logic [13:0] addr, output logic [31:0] d);
    csr_a = addr; csr_we = 1'b0;
    cyc();
    d = csr_do;
  endtask

  task automatic csr_wr(input logic [13:0] addr, input logic [31:0] data);
    csr_a = addr; csr_di = data; csr_we = 1'b1;
    cyc();
    csr_we = 1'b0;
  endtask

  task automatic pulse_err(input logic [NCHAN-1:0] m);
    error = m;
    cyc();
    error = '0;
    cyc();
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_do"}, csr_do, 32'h0);
    check({tag, "_en"}, 32'(mpu_en), 32'h0);
    check({tag, "_rst"}, 32'(mpu_rst), 32'h0);
    check({tag, "_irq"}, 32'(irq), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    logic [3:0]  bank;
    sys_rst = 1'b0; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    user_irq = '0; user_data = '0; error = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1 check_reset_zero("in_reset");
    sys_rst = 1'b1;

    // Reset state
    csr_rd(14'h003, d); check("stat_reset", d, 32'h0000_0001);
    csr_rd(14'h001, d); check("run_reset", d, 32'h0);

    // Error event auto-stops its channel and raises irq
    csr_wr(14'h000, 32'h1);
    csr_wr(14'h001, 32'hF);
    error = 4'b0100;
    cyc();
    error = '0;
    check("err2_stop", 32'(mpu_en), 32'hB);
    cyc(); cyc();
    check("irq_up", 32'(irq), 32'h1);
    csr_rd(14'h004, d); check("evt_err2", d, 32'h8000_0102);
    csr_wr(14'h010, 32'h0);
    csr_rd(14'h003, d); check("stat_popped", d, 32'h0000_0001);
    check("irq_down", 32'(irq), 32'h0);

    // User event with data keeps running; with zero data it stops
    user_data[1*UDATA_W +: UDATA_W] = '1;
    user_irq = 4'b0010;
    cyc();
    user_irq = '0;
    cyc(); cyc();
    csr_rd(14'h004, d); check("evt_usr1", d, 32'h8000_0001);
    csr_rd(14'h005, d); check("usr1_w0", d, 32'hFFFF_FFFF);
    csr_rd(14'h006, d); check("usr1_w1", d, 32'hFFFF_FFFF);
    check("usr1_run", 32'(mpu_en), 32'hB);
    csr_wr(14'h010, 32'h0);
    user_data = '0;
    user_irq = 4'b0010;
    cyc();
    user_irq = '0;
    check("usr1_end_stop", 32'(mpu_en), 32'h9);
    cyc(); cyc();
    csr_rd(14'h004, d); check("evt_usr1_end", d, 32'h8000_0001);
    csr_rd(14'h005, d); check("usr1_end_w0", d, 32'h0);
    csr_wr(14'h010, 32'h0);

    // Simultaneous errors drain lowest channel first
    error = 4'b1001;
    cyc();
    error = '0;
    cyc(); cyc(); cyc();
    csr_rd(14'h003, d); check("stat_lvl2", d, 32'h0002_0000);
    csr_rd(14'h004, d); check("evt_ch0", d, 32'h8000_0100);
    csr_wr(14'h010, 32'h0);
    csr_rd(14'h004, d); check("evt_ch3", d, 32'h8000_0103);
    csr_wr(14'h010, 32'h0);
    csr_rd(14'h003, d); check("stat_empty", d, 32'h0000_0001);

    // Fill the FIFO, overflow a pending channel, clear ovf, drain in order
    for (int k = 0; k < 10; k++) pulse_err(4'(1 << (k % 4)));
    csr_rd(14'h003, d); check("stat_full", d, 32'h0008_0002);
    pulse_err(4'b0001);
    csr_rd(14'h003, d); check("stat_ovf", d, 32'h8008_0002);
    csr_wr(14'h003, 32'h8000_0000);
    csr_rd(14'h003, d); check("stat_ovf_clr", d, 32'h0008_0002);
    for (int k = 0; k < 10; k++) begin
      csr_rd(14'h004, d); check("drain_evt", d, 32'h8000_0100 | 32'(k % 4));
      csr_wr(14'h010, 32'h0);
    end
    csr_rd(14'h003, d); check("stat_drained", d, 32'h0000_0001);

    // Per-channel reset pulse
    csr_wr(14'h001, 32'hF);
    csr_wr(14'h002, 32'h4);
    check("rst_pulse", 32'(mpu_rst), 32'h4);
    cyc();
    check("rst_pulse_end", 32'(mpu_rst), 32'h0);
    csr_rd(14'h001, d); check("run_after_rst", d, 32'hB);

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 3000; n++) begin
      error    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      user_irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      for (int c = 0; c < NCHAN; c++)
        user_data[c*UDATA_W +: UDATA_W] = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      bank = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      op   = $urandom_range(0, 9);
      csr_we = 1'b0;
      csr_di = $urandom;
      case (op)
        4, 5: begin csr_a = {bank, 10'h010}; csr_we = 1'b1; end
        6:    begin csr_a = {bank, 10'h001}; csr_we = 1'b1; end
        7:    begin csr_a = {bank, 10'h000}; csr_we = 1'b1; end
        8:    begin csr_a = {bank, 10'h003}; csr_we = 1'b1; end
        9:    begin csr_a = {bank, 10'h002}; csr_we = ($urandom_range(0, 3) == 0); end
        default: csr_a = {bank, 10'($urandom_range(0, 18))};
      endcase
      cyc();
      csr_we = 1'b0;
      if (n == 1500) begin
        #2 sys_rst = 1'b0;
        #1 check_reset_zero("mid_reset");
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
